soric_mem_xbar: RTL and testbench

SORIC_MEM_XBAR -- requirements
Module: soric_mem_xbar

---
 rtl/soric_xbar_pkg.sv | 19 +
 rtl/soric_mem_xbar_if.sv | 36 +++
 rtl/soric_rr_arbiter.sv | 48 ++++
 rtl/soric_mem_xbar.sv | 127 ++++++++++++
 tb/tb_soric_mem_xbar.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/soric_xbar_pkg.sv
// Shared types and helpers for the SRAM bank crossbar.
// Response records carry {valid, bank, err} down the per-master read-latency pipe.
package soric_xbar_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    localparam int BANK_ID_W  = 3;

    function automatic int idx_w(input int nbank);
        return (nbank > 1) ? $clog2(nbank) : 0;
    endfunction

    typedef struct packed {
        logic                 vld;
        logic [BANK_ID_W-1:0] bank;
        logic                 err;
    } rsp_t;

endpackage

// File: rtl/soric_mem_xbar_if.sv
// Core-side request/response and SRAM-side bank signals of the crossbar.
// slave = crossbar view, master = environment (cores + SRAM macros) view.
interface soric_mem_xbar_if #(
    parameter int NMASTER     = 2,
    parameter int NBANK       = 4,
    parameter int ADDR_W      = 14,
    parameter int SRAM_ADDR_W = 11
);
    logic [NMASTER-1:0]               m_req_i;
    logic [NMASTER-1:0]               m_we_i;
    logic [NMASTER*ADDR_W-1:0]        m_addr_i;
    logic [NMASTER*4-1:0]             m_be_i;
    logic [NMASTER*32-1:0]            m_wdata_i;
    logic [NMASTER-1:0]               m_gnt_o;
    logic [NMASTER-1:0]               m_rvalid_o;
    logic [NMASTER-1:0]               m_err_o;
    logic [NMASTER*32-1:0]            m_rdata_o;
    logic [NBANK-1:0]                 s_csb_o;
    logic [NBANK-1:0]                 s_web_o;
    logic [NBANK*4-1:0]               s_wmask_o;
    logic [NBANK*(SRAM_ADDR_W-2)-1:0] s_addr_o;
    logic [NBANK*32-1:0]              s_wdata_o;
    logic [NBANK*32-1:0]              s_rdata_i;

    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
        output s_csb_o, s_web_o, s_wmask_o, s_addr_o, s_wdata_o
    );

    modport master (
        output m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
        input  s_csb_o, s_web_o, s_wmask_o, s_addr_o, s_wdata_o
    );
endinterface

// File: rtl/soric_rr_arbiter.sv
// Round-robin arbiter: one-hot grant combinational from req, search starts at ptr.
// Pointer moves past the winner on a grant and holds otherwise; no backpressure.
module soric_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr, ptr_nxt, win;
    logic          found;

    // Two passes emulate a rotated priority: first ptr..N-1, then 0..ptr-1.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k] && k >= int'(ptr)) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
                win    = k[PW-1:0];
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && req[k] && k < int'(ptr)) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
                win    = k[PW-1:0];
            end
        end
        ptr_nxt = ptr;
        if (found) begin
            ptr_nxt = (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
endmodule

// File: rtl/soric_mem_xbar.sv
// NMASTER x NBANK SRAM crossbar: combinational grant, response RD_LAT cycles later.
// Losing masters hold their request until granted; out-of-range is granted at once with err.
module soric_mem_xbar
    import soric_xbar_pkg::*;
#(
    parameter int NMASTER     = 2,
    parameter int NBANK       = 4,
    parameter int ADDR_W      = 14,
    parameter int SRAM_ADDR_W = 11,
    parameter int INTERLEAVE  = 0,
    parameter int RD_LAT      = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    soric_mem_xbar_if.slave bus
);
    localparam int IDX_W   = idx_w(NBANK);
    localparam int WA_W    = SRAM_ADDR_W - 2;
    localparam int BANK_SH = (INTERLEAVE != 0) ? 2 : SRAM_ADDR_W;
    localparam int WA_SH   = (INTERLEAVE != 0) ? 2 + IDX_W : 2;
    localparam int TOP_SH  = SRAM_ADDR_W + IDX_W;
    localparam int LAT     = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                             (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [BANK_ID_W-1:0] IDX_MASK = BANK_ID_W'((1 << IDX_W) - 1);

    logic [NMASTER-1:0]               req, moor, gnt;
    logic [BANK_ID_W-1:0]             mbank [NMASTER];
    logic [WA_W-1:0]                  mwa   [NMASTER];
    logic [NBANK-1:0][NMASTER-1:0]    bgnt_all;

    // Requests are masked in reset so grants and chip selects stay idle.
    assign req = bus.m_req_i & {NMASTER{rst_ni}};

    for (genvar m = 0; m < NMASTER; m++) begin : g_dec
        assign mbank[m] = BANK_ID_W'(bus.m_addr_i[m*ADDR_W +: ADDR_W] >> BANK_SH) & IDX_MASK;
        assign mwa[m]   = WA_W'(bus.m_addr_i[m*ADDR_W +: ADDR_W] >> WA_SH);
        assign moor[m]  = ((bus.m_addr_i[m*ADDR_W +: ADDR_W] >> TOP_SH) != '0) ||
                          ({1'b0, mbank[m]} >= 4'(NBANK));
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [NMASTER-1:0] breq, bgnt;
        logic               web;
        logic [3:0]         wmask;
        logic [WA_W-1:0]    baddr;
        logic [31:0]        wdata;

        always_comb begin
            breq = '0;
            for (int m = 0; m < NMASTER; m++) begin
                breq[m] = req[m] & ~moor[m] & (mbank[m] == BANK_ID_W'(b));
            end
        end

        soric_rr_arbiter #(.N(NMASTER)) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req    (breq),
            .gnt    (bgnt)
        );

        always_comb begin
            web   = 1'b1;
            wmask = '0;
            baddr = '0;
            wdata = '0;
            for (int m = 0; m < NMASTER; m++) begin
                if (bgnt[m]) begin
                    web   = ~bus.m_we_i[m];
                    wmask = bus.m_be_i[m*4 +: 4];
                    baddr = mwa[m];
                    wdata = bus.m_wdata_i[m*32 +: 32];
                end
            end
        end

        assign bgnt_all[b]                 = bgnt;
        assign bus.s_csb_o[b]              = ~(|bgnt);
        assign bus.s_web_o[b]              = web;
        assign bus.s_wmask_o[b*4 +: 4]     = wmask;
        assign bus.s_addr_o[b*WA_W +: WA_W] = baddr;
        assign bus.s_wdata_o[b*32 +: 32]   = wdata;
    end

    always_comb begin
        gnt = req & moor;
        for (int b = 0; b < NBANK; b++) begin
            gnt = gnt | bgnt_all[b];
        end
    end

    assign bus.m_gnt_o = gnt;

    for (genvar m = 0; m < NMASTER; m++) begin : g_rsp
        rsp_t        pipe [LAT];
        rsp_t        tail;
        logic [31:0] rdata;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < LAT; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= '{vld: gnt[m], bank: mbank[m], err: moor[m]};
                for (int i = 1; i < LAT; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign tail = pipe[LAT-1];

        always_comb begin
            rdata = '0;
            for (int b = 0; b < NBANK; b++) begin
                if (tail.vld && !tail.err && tail.bank == BANK_ID_W'(b)) begin
                    rdata = bus.s_rdata_i[b*32 +: 32];
                end
            end
        end

        assign bus.m_rvalid_o[m]         = tail.vld;
        assign bus.m_err_o[m]            = tail.vld & tail.err;
        assign bus.m_rdata_o[m*32 +: 32] = rdata;
    end
endmodule

// File: tb/tb_soric_mem_xbar.sv
// Directed bench: three crossbars (contiguous/RD_LAT=1, interleaved, RD_LAT=2) with
// simple SRAM models returning 0xD0bb_00ww (bank bb, word address ww).
module tb_soric_mem_xbar;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    soric_mem_xbar_if #(.NMASTER(2), .NBANK(4), .ADDR_W(14), .SRAM_ADDR_W(11)) ifa ();
    soric_mem_xbar_if #(.NMASTER(2), .NBANK(4), .ADDR_W(14), .SRAM_ADDR_W(11)) ifb ();
    soric_mem_xbar_if #(.NMASTER(2), .NBANK(4), .ADDR_W(14), .SRAM_ADDR_W(11)) ifc ();

    soric_mem_xbar #(.NMASTER(2), .NBANK(4), .ADDR_W(14), .SRAM_ADDR_W(11),
                     .INTERLEAVE(0), .RD_LAT(1)) ua (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
    soric_mem_xbar #(.NMASTER(2), .NBANK(4), .ADDR_W(14), .SRAM_ADDR_W(11),
                     .INTERLEAVE(1), .RD_LAT(1)) ub (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));
    soric_mem_xbar #(.NMASTER(2), .NBANK(4), .ADDR_W(14), .SRAM_ADDR_W(11),
                     .INTERLEAVE(0), .RD_LAT(2)) uc (.clk_i(clk), .rst_ni(rst_n), .bus(ifc));

    function automatic logic [31:0] pat(input int b, input logic [8:0] wa);
        return 32'hD000_0000 | (32'(b) << 16) | 32'(wa);
    endfunction

    logic [31:0] a_rd [4] = '{default: 32'h0};
    logic [31:0] b_rd [4] = '{default: 32'h0};
    logic [31:0] c_rd1 [4] = '{default: 32'h0};
    logic [31:0] c_rd2 [4] = '{default: 32'h0};

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!ifa.s_csb_o[b]) a_rd[b] <= pat(b, ifa.s_addr_o[b*9 +: 9]);
            if (!ifb.s_csb_o[b]) b_rd[b] <= pat(b, ifb.s_addr_o[b*9 +: 9]);
            if (!ifc.s_csb_o[b]) c_rd1[b] <= pat(b, ifc.s_addr_o[b*9 +: 9]);
            c_rd2[b] <= c_rd1[b];
        end
    end

    assign ifa.s_rdata_i = {a_rd[3], a_rd[2], a_rd[1], a_rd[0]};
    assign ifb.s_rdata_i = {b_rd[3], b_rd[2], b_rd[1], b_rd[0]};
    assign ifc.s_rdata_i = {c_rd2[3], c_rd2[2], c_rd2[1], c_rd2[0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_a(input int m, input logic req, input logic we, input logic [13:0] addr);
        ifa.m_req_i[m]            = req;
        ifa.m_we_i[m]             = we;
        ifa.m_addr_i[m*14 +: 14]  = addr;
    endtask

    initial begin
        ifa.m_req_i = '0; ifa.m_we_i = '0; ifa.m_addr_i = '0; ifa.m_be_i = '0; ifa.m_wdata_i = '0;
        ifb.m_req_i = '0; ifb.m_we_i = '0; ifb.m_addr_i = '0; ifb.m_be_i = '0; ifb.m_wdata_i = '0;
        ifc.m_req_i = '0; ifc.m_we_i = '0; ifc.m_addr_i = '0; ifc.m_be_i = '0; ifc.m_wdata_i = '0;

        // Reset with a live request: nothing may be granted or selected.
        set_a(0, 1'b1, 1'b0, 14'h0004);
        settle();
        chk("rst_gnt", ifa.m_gnt_o, 64'h0);
        chk("rst_rvalid", ifa.m_rvalid_o, 64'h0);
        chk("rst_err", ifa.m_err_o, 64'h0);
        chk("rst_rdata", ifa.m_rdata_o, 64'h0);
        chk("rst_csb", ifa.s_csb_o, 64'hF);
        chk("rst_web", ifa.s_web_o, 64'hF);
        tick();
        set_a(0, 1'b0, 1'b0, 14'h0);
        tick();
        rst_n = 1'b1;

        // Single read of 0x0004: bank 0, word 1.
        set_a(0, 1'b1, 1'b0, 14'h0004);
        settle();
        chk("rd_gnt", ifa.m_gnt_o, 64'h1);
        chk("rd_csb", ifa.s_csb_o, 64'hE);
        chk("rd_web", ifa.s_web_o, 64'hF);
        chk("rd_addr", ifa.s_addr_o[8:0], 64'h1);
        chk("rd_rvalid_c0", ifa.m_rvalid_o, 64'h0);
        tick();
        set_a(0, 1'b0, 1'b0, 14'h0);
        settle();
        chk("rd_rvalid", ifa.m_rvalid_o, 64'h1);
        chk("rd_rdata", ifa.m_rdata_o, 64'h0000_0000_D000_0001);
        chk("rd_err", ifa.m_err_o, 64'h0);
        chk("rd_gnt_idle", ifa.m_gnt_o, 64'h0);
        tick();

        // Contention on bank 2: M0 word 0, M1 word 2, four cycles then idle.
        for (int c = 0; c < 5; c++) begin
            set_a(0, c < 4, 1'b0, 14'h1000);
            set_a(1, c < 4, 1'b0, 14'h1008);
            settle();
            chk($sformatf("rr_gnt_c%0d", c), ifa.m_gnt_o,
                (c == 4) ? 64'h0 : ((c % 2 == 0) ? 64'h1 : 64'h2));
            chk($sformatf("rr_rvalid_c%0d", c), ifa.m_rvalid_o,
                (c == 0) ? 64'h0 : ((c % 2 == 1) ? 64'h1 : 64'h2));
            if (c > 0) begin
                chk($sformatf("rr_rdata_c%0d", c), ifa.m_rdata_o,
                    (c % 2 == 1) ? 64'h0000_0000_D002_0000 : 64'hD002_0002_0000_0000);
            end
            tick();
        end
        set_a(0, 1'b0, 1'b0, 14'h0);
        set_a(1, 1'b0, 1'b0, 14'h0);
        tick();

        // Write to bank 1 word 2 with partial byte enables.
        set_a(0, 1'b1, 1'b1, 14'h0808);
        ifa.m_be_i[3:0]     = 4'b0101;
        ifa.m_wdata_i[31:0] = 32'hCAFE_BABE;
        settle();
        chk("wr_gnt", ifa.m_gnt_o, 64'h1);
        chk("wr_csb", ifa.s_csb_o, 64'hD);
        chk("wr_web", ifa.s_web_o, 64'hD);
        chk("wr_mask", ifa.s_wmask_o[7:4], 64'h5);
        chk("wr_addr", ifa.s_addr_o[17:9], 64'h2);
        chk("wr_wdata", ifa.s_wdata_o[63:32], 64'hCAFE_BABE);
        tick();
        set_a(0, 1'b0, 1'b0, 14'h0);
        ifa.m_be_i = '0;
        settle();
        chk("wr_rvalid", ifa.m_rvalid_o, 64'h1);
        chk("wr_err", ifa.m_err_o, 64'h0);
        tick();

        // Out-of-range write by M1 (bit 13 set).
        set_a(1, 1'b1, 1'b1, 14'h3FF0);
        ifa.m_be_i[7:4] = 4'hF;
        settle();
        chk("oor_gnt", ifa.m_gnt_o, 64'h2);
        chk("oor_csb", ifa.s_csb_o, 64'hF);
        tick();
        set_a(1, 1'b0, 1'b0, 14'h0);
        ifa.m_be_i = '0;
        settle();
        chk("oor_rvalid", ifa.m_rvalid_o, 64'h2);
        chk("oor_err", ifa.m_err_o, 64'h2);
        chk("oor_rdata", ifa.m_rdata_o, 64'h0);
        tick();
        settle();
        chk("oor_rvalid_end", ifa.m_rvalid_o, 64'h0);
        chk("oor_err_end", ifa.m_err_o, 64'h0);
        tick();

        // Interleaved: 0x0008 -> bank 2 word 0, 0x000C -> bank 3 word 0.
        ifb.m_req_i  = 2'b11;
        ifb.m_addr_i = {14'h000C, 14'h0008};
        settle();
        chk("il_gnt", ifb.m_gnt_o, 64'h3);
        chk("il_csb", ifb.s_csb_o, 64'h3);
        tick();
        ifb.m_req_i = 2'b00;
        settle();
        chk("il_rvalid", ifb.m_rvalid_o, 64'h3);
        chk("il_rdata", ifb.m_rdata_o, 64'hD003_0000_D002_0000);
        tick();

        // RD_LAT=2: back-to-back reads of 0x0000 and 0x0004.
        for (int c = 0; c < 5; c++) begin
            ifc.m_req_i[0]    = (c < 2);
            ifc.m_addr_i[13:0] = (c == 1) ? 14'h0004 : 14'h0000;
            settle();
            chk($sformatf("lat2_gnt_c%0d", c), ifc.m_gnt_o, (c < 2) ? 64'h1 : 64'h0);
            chk($sformatf("lat2_rvalid_c%0d", c), ifc.m_rvalid_o,
                (c == 2 || c == 3) ? 64'h1 : 64'h0);
            if (c == 2 || c == 3) begin
                chk($sformatf("lat2_rdata_c%0d", c), ifc.m_rdata_o,
                    (c == 2) ? 64'h0000_0000_D000_0000 : 64'h0000_0000_D000_0001);
            end
            tick();
        end

        // Reset right after a grant on bank 2 (moves its pointer to M1).
        set_a(0, 1'b1, 1'b0, 14'h1004);
        settle();
        chk("rr2_gnt", ifa.m_gnt_o, 64'h1);
        tick();
        rst_n = 1'b0;
        settle();
        chk("mid_rst_rvalid", ifa.m_rvalid_o, 64'h0);
        chk("mid_rst_gnt", ifa.m_gnt_o, 64'h0);
        chk("mid_rst_csb", ifa.s_csb_o, 64'hF);
        chk("mid_rst_rdata", ifa.m_rdata_o, 64'h0);
        tick();
        tick();
        set_a(0, 1'b0, 1'b0, 14'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("post_rst_rvalid_c%0d", c), ifa.m_rvalid_o, 64'h0);
            tick();
        end

        // Pointer restarts at M0 after reset.
        set_a(0, 1'b1, 1'b0, 14'h1000);
        set_a(1, 1'b1, 1'b0, 14'h1008);
        settle();
        chk("ptr_rst_gnt", ifa.m_gnt_o, 64'h1);
        tick();
        settle();
        chk("ptr_rst_gnt2", ifa.m_gnt_o, 64'h2);
        chk("ptr_rst_rvalid", ifa.m_rvalid_o, 64'h1);
        tick();
        set_a(0, 1'b0, 1'b0, 14'h0);
        set_a(1, 1'b0, 1'b0, 14'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
